// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI command/RAM controller: command codes,
// read FSM state encoding and data widths.
package spi_ram_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        CMD_WADDR = 2'b00,
        CMD_WDATA = 2'b01,
        CMD_RADDR = 2'b10,
        CMD_RDATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_FETCH = 2'b01,
        R_HOLD  = 2'b10
    } rd_state_e;

endpackage

// File: rtl/sp_ram_core.sv
// Single-port synchronous RAM, MEM_DEPTH x 8, registered read, write-first.
// The controller guarantees addr < MEM_DEPTH on every enabled access.
module sp_ram_core
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  idx;
    logic              unused_addr;

    assign idx         = addr[IDX_W-1:0];
    assign unused_addr = ^addr;
    assign rdata       = rdata_q;

    // NOTE: the storage array has no reset; clearing it would force flops instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[idx] <= wdata;
                rdata_q    <= wdata;
            end else begin
                rdata_q    <= mem_q[idx];
            end
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between the SPI slave and an internal RAM: address/data
// commands, per-direction address registers with optional wrap-around increment.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              err
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);

    // Wrap is explicit so non-power-of-two depths never address past the array.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] addr_pay;
    logic [DATA_W-1:0]    data_pay;
    logic                 pay_in_range;

    assign cmd          = cmd_e'(din[9:8]);
    assign addr_pay     = din[ADDR_SIZE-1:0];
    assign data_pay     = din[DATA_W-1:0];
    assign pay_in_range = ({1'b0, addr_pay} < DEPTH_EXT);

    rd_state_e            state_q, state_d;
    logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
    logic [ADDR_SIZE-1:0] raddr_q, raddr_d;
    logic                 waddr_ok_q, waddr_ok_d;
    logic                 raddr_ok_q, raddr_ok_d;
    logic [DATA_W-1:0]    dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 err_q, err_d;

    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [DATA_W-1:0]    ram_wdata;
    logic [DATA_W-1:0]    ram_rdata;

    sp_ram_core #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        waddr_ok_d = waddr_ok_q;
        raddr_ok_d = raddr_ok_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = raddr_q;
        ram_wdata  = data_pay;

        case (state_q)
            R_FETCH: begin
                // RAM output register holds mem[raddr]; any word arriving now is dropped.
                dout_d     = ram_rdata;
                tx_valid_d = 1'b1;
                state_d    = R_HOLD;
                if (AUTO_INC != 0) begin
                    raddr_d = next_addr(raddr_q);
                end
                if (rx_valid) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                if (rx_valid) begin
                    tx_valid_d = 1'b0;
                    state_d    = R_IDLE;
                    unique case (cmd)
                        CMD_WADDR: begin
                            if (pay_in_range) begin
                                waddr_d    = addr_pay;
                                waddr_ok_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_WDATA: begin
                            if (waddr_ok_q) begin
                                ram_en   = 1'b1;
                                ram_we   = 1'b1;
                                ram_addr = waddr_q;
                                if (AUTO_INC != 0) begin
                                    waddr_d = next_addr(waddr_q);
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_RADDR: begin
                            if (pay_in_range) begin
                                raddr_d    = addr_pay;
                                raddr_ok_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_RDATA: begin
                            if (raddr_ok_q) begin
                                ram_en   = 1'b1;
                                ram_addr = raddr_q;
                                state_d  = R_FETCH;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= R_IDLE;
            waddr_q    <= '0;
            raddr_q    <= '0;
            waddr_ok_q <= 1'b0;
            raddr_ok_q <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            waddr_ok_q <= waddr_ok_d;
            raddr_ok_q <= raddr_ok_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: three parameterisations share one word stream and
// are compared each cycle against a transaction-level reference model.
module tb_spi_ram_ctrl;

    localparam int N_DUT = 3;

    logic                   clk;
    logic                   rst_n;
    logic [9:0]             din;
    logic                   rx_valid;
    logic [N_DUT-1:0][7:0]  dout_v;
    logic [N_DUT-1:0]       tx_v;
    logic [N_DUT-1:0]       err_v;

    int n_checks;
    int n_errors;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_v[0]), .tx_valid(tx_v[0]), .err(err_v[0]));

    spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8), .AUTO_INC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_v[1]), .tx_valid(tx_v[1]), .err(err_v[1]));

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_v[2]), .tx_valid(tx_v[2]), .err(err_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int depth_of(input int k);
        return (k == 1) ? 128 : 256;
    endfunction

    function automatic bit auto_inc_of(input int k);
        return (k != 2);
    endfunction

    // Reference model: addresses as integers, memory as an array, a pending read
    // remembered as the value it will deliver one cycle later.
    int         waddr_m    [N_DUT];
    int         raddr_m    [N_DUT];
    bit         wok_m      [N_DUT];
    bit         rok_m      [N_DUT];
    bit         pend_m     [N_DUT];
    logic [7:0] pend_val_m [N_DUT];
    bit         pend_kn_m  [N_DUT];
    logic [7:0] exp_dout   [N_DUT];
    bit         dout_kn_m  [N_DUT];
    bit         exp_tx     [N_DUT];
    bit         exp_err    [N_DUT];
    logic [7:0] mem_m      [N_DUT][256];
    bit         mem_kn_m   [N_DUT][256];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void model_reset(input int k);
        waddr_m[k]   = 0;
        raddr_m[k]   = 0;
        wok_m[k]     = 1'b0;
        rok_m[k]     = 1'b0;
        pend_m[k]    = 1'b0;
        exp_dout[k]  = 8'h00;
        dout_kn_m[k] = 1'b1;
        exp_tx[k]    = 1'b0;
        exp_err[k]   = 1'b0;
    endfunction

    function automatic void model_step(input int k, input bit rv, input logic [9:0] d);
        int pay;
        pay        = int'(d[7:0]);
        exp_err[k] = 1'b0;
        if (pend_m[k]) begin
            exp_err[k]   = rv;
            exp_dout[k]  = pend_val_m[k];
            dout_kn_m[k] = pend_kn_m[k];
            exp_tx[k]    = 1'b1;
            pend_m[k]    = 1'b0;
            if (auto_inc_of(k)) raddr_m[k] = (raddr_m[k] + 1) % depth_of(k);
        end else if (rv) begin
            exp_tx[k] = 1'b0;
            case (d[9:8])
                2'b00: if (pay >= depth_of(k)) exp_err[k] = 1'b1;
                       else begin waddr_m[k] = pay; wok_m[k] = 1'b1; end
                2'b01: if (!wok_m[k]) exp_err[k] = 1'b1;
                       else begin
                           mem_m[k][waddr_m[k]]    = d[7:0];
                           mem_kn_m[k][waddr_m[k]] = 1'b1;
                           if (auto_inc_of(k)) waddr_m[k] = (waddr_m[k] + 1) % depth_of(k);
                       end
                2'b10: if (pay >= depth_of(k)) exp_err[k] = 1'b1;
                       else begin raddr_m[k] = pay; rok_m[k] = 1'b1; end
                default: if (!rok_m[k]) exp_err[k] = 1'b1;
                         else begin
                             pend_m[k]     = 1'b1;
                             pend_val_m[k] = mem_m[k][raddr_m[k]];
                             pend_kn_m[k]  = mem_kn_m[k][raddr_m[k]];
                         end
            endcase
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("err[%0d]", k), 32'(err_v[k]), 32'(exp_err[k]));
            check($sformatf("tx_valid[%0d]", k), 32'(tx_v[k]), 32'(exp_tx[k]));
            if (dout_kn_m[k]) check($sformatf("dout[%0d]", k), 32'(dout_v[k]), 32'(exp_dout[k]));
        end
    endtask

    // One word slot: drive at the falling edge, check just after the rising edge.
    task automatic drive(input bit rv, input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        rx_valid = rv;
        din      = {c, p};
        for (int k = 0; k < N_DUT; k++) model_step(k, rv, {c, p});
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 8'h00);
    endtask

    // Asynchronous reset asserted wherever the bench currently is; outputs must clear at once.
    task automatic apply_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int k = 0; k < N_DUT; k++) model_reset(k);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        din      = '0;
        for (int k = 0; k < N_DUT; k++) begin
            for (int a = 0; a < 256; a++) mem_kn_m[k][a] = 1'b0;
        end
        #3;
        apply_reset();

        // Basic write then read back.
        drive(1'b1, 2'b00, 8'h10);
        drive(1'b1, 2'b01, 8'hA5);
        drive(1'b1, 2'b10, 8'h10);
        drive(1'b1, 2'b11, 8'h00);
        idle(2);
        check("basic_dout", 32'(dout_v[0]), 32'h0000_00A5);
        check("basic_tx", 32'(tx_v[0]), 32'h1);

        // Wrap at the top of the 256-deep array.
        drive(1'b1, 2'b00, 8'hFF);
        drive(1'b1, 2'b01, 8'h11);
        drive(1'b1, 2'b01, 8'h22);
        drive(1'b1, 2'b10, 8'hFF);
        drive(1'b1, 2'b11, 8'h00);
        idle(1);
        check("wrap_first", 32'(dout_v[0]), 32'h11);
        drive(1'b1, 2'b11, 8'h00);
        check("wrap_tx_drop", 32'(tx_v[0]), 32'h0);
        idle(1);
        check("wrap_second", 32'(dout_v[0]), 32'h22);

        // Wrap at the top of the 128-deep array.
        drive(1'b1, 2'b00, 8'h7F);
        drive(1'b1, 2'b01, 8'h5A);
        drive(1'b1, 2'b01, 8'h6B);
        drive(1'b1, 2'b10, 8'h7F);
        drive(1'b1, 2'b11, 8'h00);
        idle(1);
        drive(1'b1, 2'b11, 8'h00);
        idle(1);
        check("wrap128", 32'(dout_v[1]), 32'h6B);

        // Data commands before any address command.
        apply_reset();
        drive(1'b1, 2'b01, 8'h33);
        check("wdata_noaddr", 32'(err_v[0]), 32'h1);
        drive(1'b1, 2'b11, 8'h00);
        check("rdata_noaddr", 32'(err_v[0]), 32'h1);
        idle(2);

        // Out-of-range address on the 128-deep instance.
        apply_reset();
        drive(1'b1, 2'b00, 8'h80);
        check("waddr_range", 32'(err_v[1]), 32'h1);
        drive(1'b1, 2'b01, 8'h44);
        check("wdata_after_range", 32'(err_v[1]), 32'h1);
        idle(1);

        // Word arriving during the fetch cycle is dropped.
        drive(1'b1, 2'b10, 8'h10);
        drive(1'b1, 2'b11, 8'h00);
        drive(1'b1, 2'b00, 8'h20);
        check("fetch_drop_err", 32'(err_v[0]), 32'h1);
        idle(1);
        drive(1'b1, 2'b01, 8'h77);
        idle(1);

        // Reset in the middle of a read, with a previous value still on dout.
        drive(1'b1, 2'b10, 8'h10);
        drive(1'b1, 2'b11, 8'h00);
        idle(1);
        drive(1'b1, 2'b11, 8'h00);
        apply_reset();
        drive(1'b1, 2'b11, 8'h00);
        check("rdata_after_reset", 32'(err_v[0]), 32'h1);
        idle(2);

        // Randomised word stream, biased towards the address boundaries.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] p;
            bit         rv;
            rv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       p = 8'($urandom_range(0, 255));
                1:       p = 8'(8'hF8 + 8'($urandom_range(0, 15)));
                default: p = 8'(8'h7B + 8'($urandom_range(0, 9)));
            endcase
            drive(rv, 2'($urandom_range(0, 3)), p);
            if ($urandom_range(0, 599) == 0) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
